guess_game_ctrl: RTL and testbench

- Clocked controller that sequences one round of the guess-number game between two players on a shared 4-key + enter keypad.
- Player A sets a secret sequence of 4..7 key symbols. Player B then gets up to MAX_TURNS guesses.
- Per-position match mask, length hint and win/lose flags are produced for the display/LED datapath.
- Replaces the unclocked edge-triggered input logic with a single synchronous FSM.

---
 rtl/guess_game_ctrl.sv | 169 ++++++++++++++++
 tb/tb_guess_game_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/guess_game_ctrl.sv
// Guess-number round controller: A sets a 4..7 symbol secret,
// B gets MAX_TURNS guesses; match mask, length hint, win/lose out.
module guess_game_ctrl #(
  parameter int MIN_LEN   = 4,
  parameter int MAX_LEN   = 7,
  parameter int MAX_TURNS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       I1,
  input  logic       I2,
  input  logic       I3,
  input  logic       I4,
  input  logic       enter,
  output logic       runa,
  output logic       runb,
  output logic [3:0] numa,
  output logic [3:0] numb,
  output logic [1:0] turn,
  output logic [6:0] suc,
  output logic       win,
  output logic       lose,
  output logic       equal,
  output logic       bigger,
  output logic       smaller
);

  localparam logic [2:0] S_SET   = 3'd0;
  localparam logic [2:0] S_GUESS = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_WIN   = 3'd3;
  localparam logic [2:0] S_LOSE  = 3'd4;

  localparam logic [3:0] MIN_L = 4'(MIN_LEN);
  localparam logic [3:0] MAX_L = 4'(MAX_LEN);
  localparam logic [1:0] TRN_L = 2'(MAX_TURNS);

  logic [2:0] state;
  logic [4:0] cur;
  logic [4:0] prev;
  logic [4:0] ev;
  logic       key_ev;
  logic       enter_ev;
  logic [1:0] code;
  logic [1:0] secret [MAX_LEN];
  logic [1:0] guess  [MAX_LEN];
  logic [6:0] suc_c;
  logic [7:0] lenmask;
  logic       win_c;

  assign ev       = cur & ~prev;
  assign key_ev   = |ev[3:0];
  assign enter_ev = ev[4] & ~key_ev;

  // lowest-numbered key wins when several rise together
  always_comb begin
    code = 2'd0;
    priority case (1'b1)
      ev[0]:   code = 2'd0;
      ev[1]:   code = 2'd1;
      ev[2]:   code = 2'd2;
      ev[3]:   code = 2'd3;
      default: code = 2'd0;
    endcase
  end

  always_comb begin
    suc_c = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((4'(i) < numa) && (4'(i) < numb)
          && (secret[i] == guess[i]))
        suc_c[i] = 1'b1;
    end
  end

  assign lenmask = (8'd1 << numa) - 8'd1;
  assign win_c   = (numb == numa) && (suc_c == lenmask[6:0]);

  assign runa = (state == S_SET);
  assign runb = (state == S_GUESS);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_SET;
      cur     <= '0;
      prev    <= '0;
      numa    <= '0;
      numb    <= '0;
      turn    <= '0;
      suc     <= '0;
      win     <= 1'b0;
      lose    <= 1'b0;
      equal   <= 1'b0;
      bigger  <= 1'b0;
      smaller <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        secret[i] <= '0;
        guess[i]  <= '0;
      end
    end else begin
      cur  <= {enter, I4, I3, I2, I1};
      prev <= cur;
      unique case (state)
        S_SET: begin
          if (numa == MAX_L) begin
            state <= S_GUESS;
          end else if (key_ev) begin
            for (int i = 0; i < MAX_LEN; i++)
              if (4'(i) == numa) secret[i] <= code;
            numa <= numa + 4'd1;
          end else if (enter_ev && numa >= MIN_L) begin
            state <= S_GUESS;
          end
        end
        S_GUESS: begin
          if (key_ev) begin
            if (numb < MAX_L) begin
              for (int i = 0; i < MAX_LEN; i++)
                if (4'(i) == numb) guess[i] <= code;
              numb <= numb + 4'd1;
            end
          end else if (enter_ev && numb >= MIN_L) begin
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          suc     <= suc_c;
          win     <= win_c;
          equal   <= (numb == numa);
          bigger  <= (numb < numa);
          smaller <= (numb > numa);
          if (win_c) begin
            state <= S_WIN;
          end else if ((turn + 2'd1) == TRN_L) begin
            turn  <= turn + 2'd1;
            lose  <= 1'b1;
            state <= S_LOSE;
          end else begin
            turn  <= turn + 2'd1;
            numb  <= '0;
            for (int i = 0; i < MAX_LEN; i++)
              guess[i] <= '0;
            state <= S_GUESS;
          end
        end
        S_WIN, S_LOSE: begin
          if (enter_ev) begin
            state   <= S_SET;
            numa    <= '0;
            numb    <= '0;
            turn    <= '0;
            suc     <= '0;
            win     <= 1'b0;
            lose    <= 1'b0;
            equal   <= 1'b0;
            bigger  <= 1'b0;
            smaller <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
              secret[i] <= '0;
              guess[i]  <= '0;
            end
          end
        end
        default: state <= S_SET;
      endcase
    end
  end

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Bench for guess_game_ctrl: scoreboard of per-guess results
// predicted from an independent model of the round rules.
module tb_guess_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] keys = '0;
  logic       enter = 1'b0;
  logic       runa, runb, win, lose;
  logic       equal, bigger, smaller;
  logic [3:0] numa, numb;
  logic [1:0] turn;
  logic [6:0] suc;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       win;
    logic       lose;
    logic       equal;
    logic       bigger;
    logic       smaller;
    logic [1:0] turn;
    logic [6:0] suc;
  } res_t;

  res_t        exp_q[$];
  int          sec_n = 0;
  logic [13:0] sec_c = '0;
  int          tb_turn = 0;

  localparam logic [23:0] RST_VEC = 24'h800000;

  guess_game_ctrl dut (
    .clk(clk), .reset(reset),
    .I1(keys[0]), .I2(keys[1]), .I3(keys[2]), .I4(keys[3]),
    .enter(enter),
    .runa(runa), .runb(runb),
    .numa(numa), .numb(numb),
    .turn(turn), .suc(suc),
    .win(win), .lose(lose),
    .equal(equal), .bigger(bigger), .smaller(smaller)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] allout();
    return {runa, runb, numa, numb, turn, suc,
            win, lose, equal, bigger, smaller};
  endfunction

  function automatic res_t obs();
    res_t r;
    r.win = win; r.lose = lose; r.equal = equal;
    r.bigger = bigger; r.smaller = smaller;
    r.turn = turn; r.suc = suc;
    return r;
  endfunction

  function automatic res_t model(input int gn,
                                 input logic [13:0] gc);
    res_t r;
    int   m;
    logic all;
    r = '0;
    m = (gn > 7) ? 7 : gn;
    all = 1'b1;
    for (int i = 0; i < 7; i++)
      if (i < sec_n && i < m && sec_c[2*i +: 2] == gc[2*i +: 2])
        r.suc[i] = 1'b1;
    for (int i = 0; i < sec_n; i++)
      if (!r.suc[i]) all = 1'b0;
    r.win = (m == sec_n) && all;
    r.equal = (m == sec_n);
    r.bigger = (m < sec_n);
    r.smaller = (m > sec_n);
    if (r.win) begin
      r.turn = 2'(tb_turn);
    end else if (tb_turn + 1 == 3) begin
      r.lose = 1'b1;
      r.turn = 2'd3;
    end else begin
      r.turn = 2'(tb_turn + 1);
    end
    return r;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [1:0] c);
    keys = 4'b0001 << c;
    cyc(2);
    keys = '0;
    cyc(2);
  endtask

  task automatic press_enter();
    enter = 1'b1;
    cyc(2);
    enter = 1'b0;
    cyc(2);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    exp_q.delete();
    tb_turn = 0;
  endtask

  task automatic set_secret(input int n, input logic [13:0] c);
    for (int i = 0; i < n; i++) press(c[2*i +: 2]);
    sec_n = n;
    sec_c = c;
    if (n < 7) press_enter();
  endtask

  task automatic do_guess(input int n, input logic [13:0] gc);
    res_t r, got, e;
    logic [1:0] k;
    int m;
    for (int i = 0; i < n; i++) begin
      k = 2'd0;
      if (i < 7) k = gc[2*i +: 2];
      press(k);
    end
    r = model(n, gc);
    exp_q.push_back(r);
    tb_turn = int'(r.turn);
    press_enter();
    got = obs();
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL guess_result: scoreboard empty");
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        failures++;
        $display("FAIL guess_result: got %h required %h", got, e);
      end
    end
    m = (n > 7) ? 7 : n;
    checks++;
    if (r.win || r.lose) begin
      if ({runa, runb, numb} !== {1'b0, 1'b0, 4'(m)}) begin
        failures++;
        $display("FAIL guess_state: got %b%b numb=%0d required 00 numb=%0d",
                 runa, runb, numb, m);
      end
    end else if ({runa, runb, numb} !== {1'b0, 1'b1, 4'd0}) begin
      failures++;
      $display("FAIL guess_state: got %b%b numb=%0d required 01 numb=0",
               runa, runb, numb);
    end
  endtask

  task automatic test_reset();
    cyc(3);
    reset = 1'b1;
    cyc(1);
    checks++;
    if (allout() !== RST_VEC) begin
      failures++;
      $display("FAIL reset: got %h required %h", allout(), RST_VEC);
    end
  endtask

  task automatic test_win();
    res_t r, e;
    do_reset();
    set_secret(4, 14'd228);
    checks++;
    if ({runa, runb, numa} !== {1'b0, 1'b1, 4'd4}) begin
      failures++;
      $display("FAIL secret_done: got %b%b numa=%0d required 01 numa=4",
               runa, runb, numa);
    end
    for (int i = 0; i < 4; i++) press(2'(i));
    r = model(4, 14'd228);
    exp_q.push_back(r);
    enter = 1'b1;
    cyc(2);
    checks++;
    if ({runa, runb, win} !== 3'b000) begin
      failures++;
      $display("FAIL check_latency: got %b%b%b required 000",
               runa, runb, win);
    end
    cyc(1);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL win_result: got %h required %h", obs(), e);
    end
    enter = 1'b0;
    cyc(2);
    press(2'd1);
    press_enter();
    checks++;
    if (allout() !== RST_VEC) begin
      failures++;
      $display("FAIL new_game: got %h required %h", allout(), RST_VEC);
    end
  endtask

  task automatic test_lose();
    do_reset();
    set_secret(4, 14'd228);
    for (int g = 0; g < 3; g++) do_guess(4, 14'd255);
    press(2'd0);
    checks++;
    if ({runa, runb, numb, turn, lose, suc}
        !== {1'b0, 1'b0, 4'd4, 2'd3, 1'b1, 7'b0001000}) begin
      failures++;
      $display("FAIL lose_hold: got %b%b numb=%0d turn=%0d lose=%b suc=%b",
               runa, runb, numb, turn, lose, suc);
    end
    press_enter();
    checks++;
    if (allout() !== RST_VEC) begin
      failures++;
      $display("FAIL lose_restart: got %h required %h", allout(), RST_VEC);
    end
  endtask

  task automatic test_len();
    do_reset();
    press(2'd0); press(2'd1); press(2'd2);
    press_enter();
    checks++;
    if ({runa, numa} !== {1'b1, 4'd3}) begin
      failures++;
      $display("FAIL short_enter: got runa=%b numa=%0d required 1 3",
               runa, numa);
    end
    press(2'd3); press(2'd0); press(2'd1); press(2'd2);
    sec_n = 7;
    sec_c = 14'd9444;
    checks++;
    if ({runa, runb, numa} !== {1'b0, 1'b1, 4'd7}) begin
      failures++;
      $display("FAIL auto_advance: got %b%b numa=%0d required 01 numa=7",
               runa, runb, numa);
    end
    do_guess(8, 14'd9444);
  endtask

  task automatic test_hint();
    do_reset();
    set_secret(5, 14'd228);
    do_guess(4, 14'd228);
    do_guess(6, 14'd228);
  endtask

  task automatic test_edges();
    do_reset();
    keys = 4'b0101;
    cyc(2);
    keys = '0;
    cyc(2);
    checks++;
    if (numa !== 4'd1) begin
      failures++;
      $display("FAIL simul_keys: got numa=%0d required 1", numa);
    end
    keys = 4'b0010;
    cyc(10);
    keys = '0;
    cyc(2);
    checks++;
    if (numa !== 4'd2) begin
      failures++;
      $display("FAIL held_key: got numa=%0d required 2", numa);
    end
    press(2'd2);
    press(2'd3);
    keys = 4'b0001;
    enter = 1'b1;
    cyc(2);
    keys = '0;
    enter = 1'b0;
    cyc(2);
    checks++;
    if ({runa, numa} !== {1'b1, 4'd5}) begin
      failures++;
      $display("FAIL key_enter: got runa=%b numa=%0d required 1 5",
               runa, numa);
    end
    press_enter();
    sec_n = 5;
    sec_c = 14'd228;
    do_guess(5, 14'd228);
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_secret(4, 14'd228);
    press(2'd0); press(2'd1); press(2'd2);
    checks++;
    if (numb !== 4'd3) begin
      failures++;
      $display("FAIL mid_guess: got numb=%0d required 3", numb);
    end
    do_reset();
    checks++;
    if (allout() !== RST_VEC) begin
      failures++;
      $display("FAIL reset_guess: got %h required %h", allout(), RST_VEC);
    end
    set_secret(4, 14'd228);
    for (int i = 0; i < 4; i++) press(2'(i));
    enter = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    enter = 1'b0;
    checks++;
    if (allout() !== RST_VEC) begin
      failures++;
      $display("FAIL reset_check: got %h required %h", allout(), RST_VEC);
    end
    cyc(3);
    checks++;
    if (allout() !== RST_VEC) begin
      failures++;
      $display("FAIL reset_stale: got %h required %h", allout(), RST_VEC);
    end
  endtask

  initial begin
    test_reset();
    test_win();
    test_lose();
    test_len();
    test_hint();
    test_edges();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
